// File: rtl/padd_simd_pipe_if.sv
// -----------------------------------------------------------------------------
// padd_simd_pipe_if
//
// Bundles the operand/result handshakes and sticky-flag signals of the
// packed SIMD saturating adder.
//
//   in_valid / in_ready    operand handshake (a, b, sub, sat travel with it)
//   out_valid / out_ready  result handshake (sum, lane_ovfl travel with it)
//   clr_sticky             clears the sticky overflow flags
//   sticky_ovfl            per-lane OR of lane_ovfl over transferred results
//
// Modports:
//   master - the side that supplies operands and consumes results
//   slave  - the adder itself
// -----------------------------------------------------------------------------
interface padd_simd_pipe_if #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANE_W*LANES-1:0]   a;
    logic [LANE_W*LANES-1:0]   b;
    logic                      sub;
    logic                      sat;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANE_W*LANES-1:0]   sum;
    logic [LANES-1:0]          lane_ovfl;
    logic                      clr_sticky;
    logic [LANES-1:0]          sticky_ovfl;

    modport master (
        output in_valid, a, b, sub, sat, out_ready, clr_sticky,
        input  in_ready, out_valid, sum, lane_ovfl, sticky_ovfl
    );

    modport slave (
        input  in_valid, a, b, sub, sat, out_ready, clr_sticky,
        output in_ready, out_valid, sum, lane_ovfl, sticky_ovfl
    );
endinterface

// File: rtl/padd_simd_pipe.sv
// -----------------------------------------------------------------------------
// padd_simd_pipe
//
// Two-stage pipelined SIMD adder/subtractor. The W = LANES*LANE_W operands are
// split into independent two's-complement lanes; each lane adds or subtracts,
// detects signed overflow and either saturates or wraps.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous, active-high reset
//   bus   - padd_simd_pipe_if.slave:
//             in_valid/in_ready + a, b, sub, sat    operand handshake
//             out_valid/out_ready + sum, lane_ovfl  result handshake
//             clr_sticky -> sticky_ovfl             sticky overflow flags
//
// Stage 1 registers raw lane results, overflow, overflow direction and the
// sat bit. Stage 2 applies saturation and drives the output registers.
// in_ready is the only combinational output (depends on out_ready).
// -----------------------------------------------------------------------------
module padd_simd_pipe #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    padd_simd_pipe_if.slave   bus
);

    localparam int W = LANE_W * LANES;

    // Saturation limits for one lane.
    localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic              s1_valid_q,  s1_valid_d;
    logic [W-1:0]      s1_raw_q,    s1_raw_d;
    logic [LANES-1:0]  s1_ovfl_q,   s1_ovfl_d;
    logic [LANES-1:0]  s1_neg_q,    s1_neg_d;
    logic              s1_sat_q,    s1_sat_d;

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      sum_q,       sum_d;
    logic [LANES-1:0]  lane_ovfl_q, lane_ovfl_d;
    logic [LANES-1:0]  sticky_q,    sticky_d;

    logic              adv1;
    logic              adv2;

    // ---------------------------------------------------------------------
    // Stage-1 lane arithmetic (combinational, from the bus operands)
    // ---------------------------------------------------------------------
    logic [W-1:0]      lane_raw;
    logic [LANES-1:0]  lane_ov;
    logic [LANES-1:0]  lane_neg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane_alu
            logic [LANE_W-1:0] op_a;
            logic [LANE_W-1:0] op_b;
            logic [LANE_W-1:0] raw;

            assign op_a = bus.a[gi*LANE_W +: LANE_W];
            // Subtraction is a + ~b + 1 with the +1 injected inside the lane,
            // so no carry ever crosses into a neighbouring lane.
            assign op_b = bus.sub ? ~bus.b[gi*LANE_W +: LANE_W]
                                  :  bus.b[gi*LANE_W +: LANE_W];
            assign raw  = op_a + op_b + {{(LANE_W-1){1'b0}}, bus.sub};

            assign lane_raw[gi*LANE_W +: LANE_W] = raw;
            // With b already inverted for subtraction, both the add and the
            // sub rule reduce to: effective operands share a sign and the
            // result's sign differs from it.
            assign lane_ov[gi]  = (op_a[LANE_W-1] == op_b[LANE_W-1]) &&
                                  (raw[LANE_W-1]  != op_a[LANE_W-1]);
            // On overflow, a's sign gives the direction (1 = negative).
            assign lane_neg[gi] = op_a[LANE_W-1];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Stage-2 saturation (combinational, from stage-1 registers)
    // ---------------------------------------------------------------------
    logic [W-1:0] sat_res;

    generate
        for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane_sat
            logic [LANE_W-1:0] limit;

            assign limit = s1_neg_q[gi] ? LANE_MIN : LANE_MAX;
            assign sat_res[gi*LANE_W +: LANE_W] =
                (s1_sat_q && s1_ovfl_q[gi]) ? limit
                                            : s1_raw_q[gi*LANE_W +: LANE_W];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // Hold everything by default; stalled stages keep data and valid.
        s1_valid_d  = s1_valid_q;
        s1_raw_d    = s1_raw_q;
        s1_ovfl_d   = s1_ovfl_q;
        s1_neg_d    = s1_neg_q;
        s1_sat_d    = s1_sat_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        lane_ovfl_d = lane_ovfl_q;

        // A stage may advance when it is empty or its successor advances.
        adv2 = ~out_valid_q | bus.out_ready;
        adv1 = ~s1_valid_q  | adv2;

        if (adv1) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_raw_d  = lane_raw;
                s1_ovfl_d = lane_ov;
                s1_neg_d  = lane_neg;
                s1_sat_d  = bus.sat;
            end
        end

        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d       = sat_res;
                lane_ovfl_d = s1_ovfl_q;
            end
        end

        // Clear first, then OR in the transferring result, so an overflow
        // that leaves in the clear cycle is not lost.
        sticky_d = (bus.clr_sticky ? {LANES{1'b0}} : sticky_q) |
                   ((out_valid_q & bus.out_ready) ? lane_ovfl_q : {LANES{1'b0}});
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_raw_q    <= '0;
            s1_ovfl_q   <= '0;
            s1_neg_q    <= '0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            lane_ovfl_q <= '0;
            sticky_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_raw_q    <= s1_raw_d;
            s1_ovfl_q   <= s1_ovfl_d;
            s1_neg_q    <= s1_neg_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            lane_ovfl_q <= lane_ovfl_d;
            sticky_q    <= sticky_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.in_ready    = adv1;
    assign bus.out_valid   = out_valid_q;
    assign bus.sum         = sum_q;
    assign bus.lane_ovfl   = lane_ovfl_q;
    assign bus.sticky_ovfl = sticky_q;

endmodule
